// File: rtl/servo_pkg.sv
// Shared types, default timing and the position-to-pulse-width rule for the servo PWM block.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } servo_state_t;

  localparam int unsigned DEF_CLK_HZ   = 100_000_000;
  localparam int unsigned DEF_FRAME_US = 20000;
  localparam int unsigned DEF_MIN_US   = 1000;
  localparam int unsigned DEF_SPAN_US  = 1000;
  localparam int unsigned DEF_POS_W    = 8;

  // Truncating scale: no rounding, the shift stands in for division by 2**pos_w.
  function automatic int unsigned pos_to_us(input int unsigned pos,
                                            input int unsigned min_us,
                                            input int unsigned span_us,
                                            input int unsigned pos_w);
    return min_us + ((pos * span_us) >> pos_w);
  endfunction

endpackage

// File: rtl/servo_pwm_ctrl_tick.sv
// Microsecond prescaler: one-cycle tick every DIV clocks, held at zero while clear is high.
module us_tick_gen #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Hobby-servo PWM sequencer: fixed frame, pulse width from a buffered position command applied at frame start.
module servo_pwm_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
  parameter int unsigned FRAME_US = DEF_FRAME_US,
  parameter int unsigned MIN_US   = DEF_MIN_US,
  parameter int unsigned SPAN_US  = DEF_SPAN_US,
  parameter int unsigned POS_W    = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pos_valid,
  input  logic [POS_W-1:0] pos_data,
  output logic             pos_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned US_DIV = CLK_HZ / 1_000_000;
  localparam int unsigned US_W   = $clog2(FRAME_US);
  localparam logic [US_W-1:0] FRAME_LAST = US_W'(FRAME_US - 1);
  localparam logic [US_W-1:0] CENTER_US  =
    US_W'(pos_to_us(1 << (POS_W - 1), MIN_US, SPAN_US, POS_W));

  if (MIN_US + SPAN_US >= FRAME_US) begin : g_bad_timing
    $error("servo_pwm_ctrl: MIN_US + SPAN_US must be below FRAME_US");
  end
  if (US_DIV < 1) begin : g_bad_clk
    $error("servo_pwm_ctrl: CLK_HZ must be at least 1 MHz");
  end

  servo_state_t    state, state_nxt;
  logic [US_W-1:0] us_cnt;
  logic [US_W-1:0] active_width;
  logic [US_W-1:0] pend_width;
  logic [US_W-1:0] req_width;
  logic            pend_full;
  logic            us_tick;
  logic            pulse_end, frame_end, start_frame, accept;
  logic            pwm_d, frame_start_d, busy_d;

  us_tick_gen #(
    .DIV(US_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .tick (us_tick)
  );

  assign req_width   = US_W'(pos_to_us(32'(pos_data), MIN_US, SPAN_US, POS_W));
  assign pos_ready   = ~pend_full;
  assign accept      = pos_valid && !pend_full;
  assign pulse_end   = (state == HIGH) && us_tick && (us_cnt == active_width - US_W'(1));
  assign frame_end   = (state == LOW) && us_tick && (us_cnt == FRAME_LAST);
  assign start_frame = enable && ((state == IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = HIGH;
      HIGH:    if (pulse_end) state_nxt = LOW;
      LOW:     if (frame_end) state_nxt = enable ? HIGH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pwm_d         = (state_nxt == HIGH);
    frame_start_d = start_frame;
    busy_d        = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pwm_out     <= pwm_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
    end
  end

  // us_cnt runs across both phases so the LOW phase ends at the same count every frame.
  always_ff @(posedge clk) begin
    if (rst || start_frame || frame_end) begin
      us_cnt <= '0;
    end else if (state != IDLE && us_tick) begin
      us_cnt <= us_cnt + US_W'(1);
    end
  end

  // Pending slot only drains on a frame start, so a pulse in flight never changes width.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full    <= 1'b0;
      active_width <= CENTER_US;
    end else if (start_frame && pend_full) begin
      pend_full    <= 1'b0;
      active_width <= pend_width;
    end else if (accept) begin
      pend_full    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_width <= req_width;
    end
  end

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Scoreboard bench for servo_pwm_ctrl on a scaled-down timebase (4 clocks per us, 300 us frame).
module tb_servo_pwm_ctrl;

  localparam int CLK_HZ   = 4_000_000;
  localparam int FRAME_US = 300;
  localparam int MIN_US   = 100;
  localparam int SPAN_US  = 100;
  localparam int POS_W    = 8;
  localparam int DIV      = CLK_HZ / 1_000_000;
  localparam int FR       = FRAME_US * DIV;
  localparam int CENTER   = MIN_US + (128 * SPAN_US) / 256;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             pos_valid;
  logic [POS_W-1:0] pos_data;
  logic             pos_ready;
  logic             pwm_out;
  logic             frame_start;
  logic             busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  int exp_w[128];
  int exp_start[128];
  bit aborted[128];
  int exp_q[$];

  servo_pwm_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .FRAME_US(FRAME_US),
    .MIN_US  (MIN_US),
    .SPAN_US (SPAN_US),
    .POS_W   (POS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pos_valid  (pos_valid),
    .pos_data   (pos_data),
    .pos_ready  (pos_ready),
    .pwm_out    (pwm_out),
    .frame_start(frame_start),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wus(input int p);
    return MIN_US + (p * SPAN_US) / (1 << POS_W);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s: timed out, got no event, expected one (cycle %0d)", nm, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input string nm, input int budget);
    int n = 0;
    while (frame_start !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    if (frame_start !== 1'b1) timeout_fail(nm);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    if (busy !== 1'b0) timeout_fail(nm);
  endtask

  task automatic send(input int p, input int budget);
    int n = 0;
    bit done = 0;
    pos_valid = 1'b1;
    pos_data  = POS_W'(p);
    while (!done && n < budget) begin
      if (pos_ready === 1'b1) done = 1;
      tick(1);
      n++;
    end
    pos_valid = 1'b0;
    pos_data  = POS_W'($urandom);
    if (!done) timeout_fail("send_accept");
  endtask

  // Reference model: frame timeline, one pending slot, active width; predicts every frame.
  initial begin
    int m_busy, m_t, m_w, m_pend, m_id;
    bit start, acc;
    m_busy = 0; m_t = 0; m_w = CENTER; m_pend = -1; m_id = 0;
    forever begin
      @(negedge clk);
      chk("pos_ready", pos_ready, (m_pend < 0));
      chk("busy", busy, m_busy);
      if (rst) begin
        if (m_busy != 0 && m_id > 0 && m_id <= 128) aborted[m_id-1] = 1;
        m_busy = 0; m_pend = -1; m_w = CENTER;
      end else begin
        start = 0;
        acc   = pos_valid && (m_pend < 0);
        if (m_busy != 0) begin
          if (m_t == FR - 1) begin
            if (enable) start = 1;
            else m_busy = 0;
          end else begin
            m_t++;
          end
        end else if (enable) begin
          start = 1;
        end
        if (start) begin
          m_busy = 1;
          m_t    = 0;
          if (m_pend >= 0) begin
            m_w    = m_pend;
            m_pend = -1;
          end
          if (m_id < 128) begin
            exp_w[m_id]     = m_w * DIV;
            exp_start[m_id] = cyc + 1;
            aborted[m_id]   = 0;
            exp_q.push_back(m_id);
          end
          m_id++;
        end
        if (acc) m_pend = wus(int'(pos_data));
      end
    end
  end

  // Monitor: each DUT frame_start pops a predicted frame and checks its start cycle and pulse length.
  initial begin
    int id, n;
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_start", exp_q.size(), 1);
        end else begin
          id = exp_q.pop_front();
          chk("frame_start_cycle", cyc, exp_start[id]);
          n = 0;
          while (pwm_out === 1'b1 && n < 100000) begin
            n++;
            @(negedge clk);
          end
          if (!aborted[id]) chk("pulse_cycles", n, exp_w[id]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; pos_valid = 1'b0; pos_data = '0;
    tick(3);
    chk("reset_pwm_out", pwm_out, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pos_ready", pos_ready, 1);
    rst = 1'b0; enable = 1'b1;

    wait_fs("first_frame_start", 10);
    tick(200);
    send(0, 3 * FR);
    wait_fs("frame2_start", FR + 10);
    tick(50);
    send(255, 3 * FR);
    send(64, 3 * FR);
    wait_fs("frame4_start", FR + 10);

    tick(10 * DIV);
    enable = 1'b0;
    wait_idle("idle_after_disable", 2 * FR);
    tick(2 * FR);
    chk("idle_pwm_low", pwm_out, 0);

    enable = 1'b1;
    wait_fs("restart_frame_start", 10);
    tick(5);
    send(200, 3 * FR);
    tick(20);
    rst = 1'b1;
    tick(1);
    chk("midframe_rst_pwm", pwm_out, 0);
    chk("midframe_rst_ready", pos_ready, 1);
    chk("midframe_rst_busy", busy, 0);
    rst = 1'b0;
    tick(3 * FR + 10);

    repeat (10) begin
      enable = 1'b1;
      tick($urandom_range(20, 900));
      send($urandom_range(0, 255), 3 * FR);
      if ($urandom_range(0, 3) == 0) enable = 1'b0;
    end

    enable = 1'b0;
    wait_idle("final_idle", 2 * FR + 10);
    tick(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
